// File: rtl/bin_to_qdi_1of4_pkg.sv
// ---------------------------------------------------------------------------
// bin_to_qdi_1of4_pkg
// Shared definitions for the binary <-> e1of4 four-phase channel:
//   - DATA_W / RAILS width constants
//   - sender_state_e : transmit FSM states (IDLE, SEND, WAIT_N)
//   - onehot_encode  : binary value -> single-rail-high code word
//   - onehot_decode  : single-rail-high code word -> binary index
// ---------------------------------------------------------------------------
package bin_to_qdi_1of4_pkg;

    localparam int DATA_W = 2;
    localparam int RAILS  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT_N = 2'd2
    } sender_state_e;

    function automatic logic [RAILS-1:0] onehot_encode(input logic [DATA_W-1:0] value);
        logic [RAILS-1:0] rails;
        rails        = '0;
        rails[value] = 1'b1;
        return rails;
    endfunction

    // Only meaningful for a single-rail-high input; callers qualify with $onehot.
    function automatic logic [DATA_W-1:0] onehot_decode(input logic [RAILS-1:0] rails);
        logic [DATA_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < RAILS; i++) begin
            if (rails[i]) idx = DATA_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bin_to_qdi_1of4_if.sv
// ---------------------------------------------------------------------------
// bin_to_qdi_1of4_if
// One e1of4 channel plus its binary side.
//   data  : binary token value
//   valid : binary-side request (sender) / token-present flag (receiver)
//   rails : e1of4 data rails, one-hot or neutral
//   en    : enable/acknowledge travelling against the data
// Modports:
//   master : drives the rails (sender view)
//   slave  : consumes the rails, drives en/data/valid (receiver view)
// ---------------------------------------------------------------------------
interface bin_to_qdi_1of4_if;
    import bin_to_qdi_1of4_pkg::*;

    logic [DATA_W-1:0] data;
    logic              valid;
    logic [RAILS-1:0]  rails;
    logic              en;

    modport master (input data, input valid, input en, output rails);
    modport slave  (input rails, output en, output data, output valid);

endinterface

// File: rtl/qdi_to_bin_1of4.sv
// ---------------------------------------------------------------------------
// qdi_to_bin_1of4
// Four-phase e1of4 receiver. Accepts a token when exactly one rail is high
// while the enable is up, then drops the enable until the rails return to
// neutral. Multi-rail patterns are ignored.
// Ports:
//   CLK   : clock, rising edge
//   RESET : asynchronous active-low reset
//   rx    : slave modport (rails in; en, data, valid out)
// Parameter:
//   RXE_RST_VAL : enable value held during reset
// ---------------------------------------------------------------------------
module qdi_to_bin_1of4
    import bin_to_qdi_1of4_pkg::*;
#(
    parameter logic RXE_RST_VAL = 1'b0
) (
    input  logic            CLK,
    input  logic            RESET,
    bin_to_qdi_1of4_if.slave rx
);

    logic              rxe_q,   rxe_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned -- that is what keeps a latch from being inferred.
    always_comb begin
        rxe_d   = rxe_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q) begin
            // Return-to-neutral completes the handshake.
            if (rx.rails == '0) begin
                valid_d = 1'b0;
                rxe_d   = 1'b1;
            end
        end else if (!rxe_q) begin
            // Only reachable straight out of reset: open the channel.
            rxe_d = 1'b1;
        end else if ($onehot(rx.rails)) begin
            data_d  = onehot_decode(rx.rails);
            valid_d = 1'b1;
            rxe_d   = 1'b0;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop sees
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rxe_q   <= RXE_RST_VAL;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            rxe_q   <= rxe_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign rx.en    = rxe_q;
    assign rx.valid = valid_q;
    assign rx.data  = data_q;

endmodule

// File: rtl/bin_to_qdi_1of4.sv
// ---------------------------------------------------------------------------
// bin_to_qdi_1of4
// Binary <-> e1of4 four-phase bridge: a sender (IDLE/SEND/WAIT_N) turning
// tx_data into a one-hot token on Tx, and a receiver (qdi_to_bin_1of4)
// decoding Rx into rx_data/rx_valid. Both sides run independently.
// Ports:
//   CLK       : clock, rising edge
//   RESET     : asynchronous active-low reset
//   VDD, GND  : supply pins, no logic function
//   tx_data   : binary value to send
//   go        : level-sensitive transmit request
//   Tx        : outgoing e1of4 rails
//   Txe       : downstream enable/acknowledge
//   Rx        : incoming e1of4 rails
//   Rxe       : upstream enable/acknowledge
//   rx_data   : last decoded value
//   rx_valid  : a received token is present
// Configuration macro:
//   SYNC_EN : when defined, Txe and Rx pass through two-flop synchronizers
//             (3-cycle latency); otherwise they feed the state flops directly
//             (1-cycle latency).
// ---------------------------------------------------------------------------
module bin_to_qdi_1of4
    import bin_to_qdi_1of4_pkg::*;
#(
    parameter logic RXE_RST_VAL = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET,
    inout  wire               VDD,
    inout  wire               GND,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              go,
    output logic [RAILS-1:0]  Tx,
    input  logic              Txe,
    input  logic [RAILS-1:0]  Rx,
    output logic              Rxe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid
);

    logic unused_supply;
    assign unused_supply = VDD ^ GND;

    // Versions of the asynchronous inputs as seen by the state logic.
    logic             txe_s;
    logic [RAILS-1:0] rx_s;

`ifdef SYNC_EN
    logic [1:0]       txe_sync_q;
    logic [RAILS-1:0] rx_sync1_q, rx_sync2_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            txe_sync_q <= '0;
            rx_sync1_q <= '0;
            rx_sync2_q <= '0;
        end else begin
            txe_sync_q <= {txe_sync_q[0], Txe};
            rx_sync1_q <= Rx;
            rx_sync2_q <= rx_sync1_q;
        end
    end

    assign txe_s = txe_sync_q[1];
    assign rx_s  = rx_sync2_q;
`else
    assign txe_s = Txe;
    assign rx_s  = Rx;
`endif

    // ---------------- sender ----------------
    sender_state_e    state_q, state_d;
    logic [RAILS-1:0] tx_q, tx_d;

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                // tx_data is captured here and held on Tx until Txe falls.
                if (go && txe_s) begin
                    tx_d    = onehot_encode(tx_data);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!txe_s) begin
                    tx_d    = '0;
                    state_d = WAIT_N;
                end
            end
            WAIT_N: begin
                if (txe_s) state_d = IDLE;
            end
            default: begin
                tx_d    = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
        end
    end

    assign Tx = tx_q;

    // ---------------- receiver ----------------
    bin_to_qdi_1of4_if rx_ch ();

    assign rx_ch.rails = rx_s;

    qdi_to_bin_1of4 #(
        .RXE_RST_VAL (RXE_RST_VAL)
    ) u_rx (
        .CLK   (CLK),
        .RESET (RESET),
        .rx    (rx_ch)
    );

    assign Rxe      = rx_ch.en;
    assign rx_data  = rx_ch.data;
    assign rx_valid = rx_ch.valid;

endmodule

// File: tb/tb_bin_to_qdi_1of4.sv
// ---------------------------------------------------------------------------
// tb_bin_to_qdi_1of4
// Directed bench for bin_to_qdi_1of4 in its default build (1-cycle latency).
// Inputs change on the falling edge and outputs are sampled there too.
// A loop_en switch connects Tx->Rx and Rxe->Txe.
// ---------------------------------------------------------------------------
module tb_bin_to_qdi_1of4;
    import bin_to_qdi_1of4_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    wire  vdd;
    wire  gnd;
    assign vdd = 1'b1;
    assign gnd = 1'b0;

    logic             loop_en     = 1'b0;
    logic [1:0]       tx_data_drv = 2'b00;
    logic             go_drv      = 1'b0;
    logic             txe_drv     = 1'b1;
    logic [3:0]       rx_drv      = 4'b0000;

    int errors = 0;
    int checks = 0;

    bin_to_qdi_1of4_if tx_ch ();
    bin_to_qdi_1of4_if rx_ch ();

    assign tx_ch.data  = tx_data_drv;
    assign tx_ch.valid = go_drv;
    assign tx_ch.en    = loop_en ? rx_ch.en : txe_drv;
    assign rx_ch.rails = loop_en ? tx_ch.rails : rx_drv;

    bin_to_qdi_1of4 dut (
        .CLK      (clk),
        .RESET    (rst_n),
        .VDD      (vdd),
        .GND      (gnd),
        .tx_data  (tx_ch.data),
        .go       (tx_ch.valid),
        .Tx       (tx_ch.rails),
        .Txe      (tx_ch.en),
        .Rx       (rx_ch.rails),
        .Rxe      (rx_ch.en),
        .rx_data  (rx_ch.data),
        .rx_valid (rx_ch.valid)
    );

    always #50ps clk = ~clk;

    initial begin
        #1000000ps;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Reset held 1000 ps with Txe=1: everything quiet, Rxe low; Rxe rises
    // on the first edge after release.
    task automatic test_reset();
        repeat (9) begin
            @(negedge clk);
            checks++;
            if ({tx_ch.rails, rx_ch.valid, rx_ch.data, rx_ch.en} !== 8'b0000_0_00_0) begin
                errors++;
                $display("FAIL reset_hold: got Tx/valid/data/Rxe=%b expected 00000000",
                         {tx_ch.rails, rx_ch.valid, rx_ch.data, rx_ch.en});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_ch.rails, rx_ch.valid, rx_ch.en} !== 6'b0000_0_1) begin
            errors++;
            $display("FAIL reset_release: got Tx/valid/Rxe=%b expected 000001",
                     {tx_ch.rails, rx_ch.valid, rx_ch.en});
        end
    endtask

    // One token of 11 with a manual Txe, then a back-to-back 00 token.
    task automatic test_single_token();
        loop_en     = 1'b0;
        txe_drv     = 1'b1;
        tx_data_drv = 2'b11;
        go_drv      = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_ch.rails !== 4'b1000) begin
            errors++;
            $display("FAIL single_send: got Tx=%b expected 1000", tx_ch.rails);
        end
        // Changing tx_data while SEND must not disturb Tx.
        tx_data_drv = 2'b00;
        @(negedge clk);
        checks++;
        if (tx_ch.rails !== 4'b1000) begin
            errors++;
            $display("FAIL single_hold: got Tx=%b expected 1000", tx_ch.rails);
        end
        txe_drv = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_ch.rails !== 4'b0000) begin
            errors++;
            $display("FAIL single_neutral: got Tx=%b expected 0000", tx_ch.rails);
        end
        // go still high but Txe low: no new token.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (tx_ch.rails !== 4'b0000) begin
                errors++;
                $display("FAIL single_no_refire[%0d]: got Tx=%b expected 0000", k, tx_ch.rails);
            end
        end
        txe_drv = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_ch.rails !== 4'b0000) begin
            errors++;
            $display("FAIL single_wait_exit: got Tx=%b expected 0000", tx_ch.rails);
        end
        @(negedge clk);
        checks++;
        if (tx_ch.rails !== 4'b0001) begin
            errors++;
            $display("FAIL back_to_back: got Tx=%b expected 0001", tx_ch.rails);
        end
        go_drv  = 1'b0;
        txe_drv = 1'b0;
        @(negedge clk);
        txe_drv = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Multi-rail patterns are ignored whether idle or holding a token.
    task automatic test_illegal_rx();
        loop_en = 1'b0;
        rx_drv  = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({rx_ch.valid, rx_ch.en} !== 2'b01) begin
                errors++;
                $display("FAIL illegal_0101[%0d]: got valid/Rxe=%b expected 01", k,
                         {rx_ch.valid, rx_ch.en});
            end
        end
        rx_drv = 4'b0100;
        @(negedge clk);
        checks++;
        if ({rx_ch.valid, rx_ch.en, rx_ch.data} !== 4'b1_0_10) begin
            errors++;
            $display("FAIL rx_accept: got valid/Rxe/data=%b expected 1010",
                     {rx_ch.valid, rx_ch.en, rx_ch.data});
        end
        rx_drv = 4'b1100;
        @(negedge clk);
        checks++;
        if ({rx_ch.valid, rx_ch.en, rx_ch.data} !== 4'b1_0_10) begin
            errors++;
            $display("FAIL illegal_while_valid: got valid/Rxe/data=%b expected 1010",
                     {rx_ch.valid, rx_ch.en, rx_ch.data});
        end
        rx_drv = 4'b0000;
        @(negedge clk);
        checks++;
        if ({rx_ch.valid, rx_ch.en, rx_ch.data} !== 4'b0_1_10) begin
            errors++;
            $display("FAIL rx_release: got valid/Rxe/data=%b expected 0110",
                     {rx_ch.valid, rx_ch.en, rx_ch.data});
        end
    endtask

    // Loopback sweep of all four values.
    task automatic test_encoding_sweep();
        logic [3:0] exp_rails [4];
        logic [1:0] exp_data  [4];
        int         n;
        exp_rails = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_data  = '{2'b00, 2'b01, 2'b10, 2'b11};
        loop_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_data_drv = exp_data[i];
            go_drv      = 1'b1;
            n = 0;
            while (tx_ch.rails == 4'b0000 && n < 10) begin
                @(negedge clk);
                n++;
            end
            go_drv = 1'b0;
            checks++;
            if (tx_ch.rails !== exp_rails[i]) begin
                errors++;
                $display("FAIL enc_tx[%0d]: got Tx=%b expected %b", i, tx_ch.rails, exp_rails[i]);
            end
            n = 0;
            while (rx_ch.valid !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if ({rx_ch.valid, rx_ch.data} !== {1'b1, exp_data[i]}) begin
                errors++;
                $display("FAIL enc_rx[%0d]: got valid/data=%b expected %b", i,
                         {rx_ch.valid, rx_ch.data}, {1'b1, exp_data[i]});
            end
            n = 0;
            while (!(rx_ch.valid === 1'b0 && rx_ch.en === 1'b1 && tx_ch.rails === 4'b0000)
                   && n < 10) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if ({rx_ch.valid, rx_ch.en, tx_ch.rails} !== 6'b0_1_0000) begin
                errors++;
                $display("FAIL enc_idle[%0d]: got valid/Rxe/Tx=%b expected 010000", i,
                         {rx_ch.valid, rx_ch.en, tx_ch.rails});
            end
            @(negedge clk);
        end
        loop_en = 1'b0;
    endtask

    // Ten tokens of 11 in loopback; count receiver acceptances.
    task automatic test_loopback();
        int         issued;
        int         rises;
        logic [3:0] prev_tx;
        logic       prev_valid;
        issued      = 0;
        rises       = 0;
        loop_en     = 1'b1;
        tx_data_drv = 2'b11;
        go_drv      = 1'b1;
        prev_tx     = tx_ch.rails;
        prev_valid  = rx_ch.valid;
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            if (prev_tx == 4'b0000 && tx_ch.rails != 4'b0000) begin
                issued++;
                if (issued >= 10) go_drv = 1'b0;
            end
            if (!prev_valid && rx_ch.valid) begin
                rises++;
                checks++;
                if (rx_ch.data !== 2'b11) begin
                    errors++;
                    $display("FAIL loop_data[%0d]: got rx_data=%b expected 11", rises, rx_ch.data);
                end
            end
            prev_tx    = tx_ch.rails;
            prev_valid = rx_ch.valid;
        end
        go_drv = 1'b0;
        checks++;
        if (rises != 10) begin
            errors++;
            $display("FAIL loop_rises: got %0d expected 10", rises);
        end
        checks++;
        if (issued != 10) begin
            errors++;
            $display("FAIL loop_issued: got %0d expected 10", issued);
        end
        checks++;
        if ({rx_ch.valid, rx_ch.en} !== 2'b01) begin
            errors++;
            $display("FAIL loop_end: got valid/Rxe=%b expected 01", {rx_ch.valid, rx_ch.en});
        end
        loop_en = 1'b0;
    endtask

    // Reset asserted while Tx=0100: Tx clears at once, nothing is re-sent.
    task automatic test_reset_mid_handshake();
        loop_en     = 1'b0;
        txe_drv     = 1'b1;
        rx_drv      = 4'b0000;
        tx_data_drv = 2'b10;
        go_drv      = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_ch.rails !== 4'b0100) begin
            errors++;
            $display("FAIL mid_send: got Tx=%b expected 0100", tx_ch.rails);
        end
        go_drv = 1'b0;
        #20ps;
        rst_n = 1'b0;
        #1ps;
        checks++;
        if ({tx_ch.rails, rx_ch.valid, rx_ch.en} !== 6'b0000_0_0) begin
            errors++;
            $display("FAIL mid_async_reset: got Tx/valid/Rxe=%b expected 000000",
                     {tx_ch.rails, rx_ch.valid, rx_ch.en});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (tx_ch.rails !== 4'b0000) begin
                errors++;
                $display("FAIL mid_no_token[%0d]: got Tx=%b expected 0000", k, tx_ch.rails);
            end
        end
        tx_data_drv = 2'b01;
        go_drv      = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_ch.rails !== 4'b0010) begin
            errors++;
            $display("FAIL mid_resume: got Tx=%b expected 0010", tx_ch.rails);
        end
        go_drv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_token();
        test_illegal_rx();
        test_encoding_sweep();
        test_loopback();
        test_reset_mid_handshake();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
